// File: rtl/control_sequencer.sv
// Three-clock-per-instruction sequencer: fetches opcode/immediate from an external
// program memory addressed by count, and executes load/ALU operations on A, B and result.
module control_sequencer #(
    parameter int PROG_LEN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] Opcode,
    input  logic [3:0] in,
    output logic [2:0] count,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic [7:0] result,
    output logic       res_valid,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_STEP  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] LAST_PC = 3'(PROG_LEN - 1);

    state_t     state, state_nxt;
    logic [2:0] pc, pc_nxt;
    logic [2:0] ir;
    logic [3:0] imm;

    // start is a level request with no handshake: it is only looked at in IDLE
    // and HALT, and is silently ignored while a program is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= 3'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nxt    = 3'd0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_STEP;
            S_STEP: begin
                if (pc == LAST_PC) begin
                    state_nxt = S_HALT;
                end else begin
                    pc_nxt    = pc + 3'd1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = 3'd0;
            end
        endcase
    end

    // Datapath: latch the instruction in FETCH, apply it at the EXEC edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir        <= 3'd0;
            imm       <= 4'd0;
            reg_a     <= 4'd0;
            reg_b     <= 4'd0;
            result    <= 8'd0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (state == S_FETCH) begin
                ir  <= Opcode;
                imm <= in;
            end
            if (state == S_EXEC) begin
                unique case (ir)
                    OP_CLR: begin
                        reg_a  <= 4'd0;
                        reg_b  <= 4'd0;
                        result <= 8'd0;
                    end
                    OP_LDA: reg_a <= imm;
                    OP_LDB: reg_b <= imm;
                    OP_ADD: begin
                        result    <= {4'b0, reg_a} + {4'b0, reg_b};
                        res_valid <= 1'b1;
                    end
                    OP_SUB: begin
                        result    <= {4'b0, reg_a} - {4'b0, reg_b};
                        res_valid <= 1'b1;
                    end
                    OP_MUL: begin
                        result    <= {4'b0, reg_a} * {4'b0, reg_b};
                        res_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign count     = pc;
    assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_STEP);
    assign done      = (state == S_HALT);
    assign state_dbg = state;

endmodule
